// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// count, threshold flags and sticky overflow/underflow error flags.
module fifo_sync #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          clr_err,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  rd_ok;
    logic                  wr_ok;

    assign full         = (count_reg == CW'(FIFO_DEPTH));
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= CW'(AF_LEVEL));
    assign almost_empty = (count_reg <= CW'(AE_LEVEL));
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A read frees a slot on the same edge, so a full FIFO still takes a write
    // when a read is accepted alongside it. No bypass when empty.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            // A new error in the same cycle as clr_err wins.
            overflow_reg  <= (overflow_reg  && !clr_err) || (wr_en && !wr_ok);
            underflow_reg <= (underflow_reg && !clr_err) || (rd_en && empty);
        end
    end

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_reg] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; rd_en only pops it.
            assign data_out = mem[rd_ptr_reg];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] data_out_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_out_reg <= '0;
                end else if (rd_ok) begin
                    data_out_reg <= mem[rd_ptr_reg];
                end
            end

            assign data_out = data_out_reg;
        end
    endgenerate

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of words (power of two, >= 2).
REQ-003 SHALL have parameter AF_LEVEL, default 14, almost_full threshold (1..FIFO_DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (1..FIFO_DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 standard (registered), 1 first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port data_in  input  FIFO_WIDTH  write data.
REQ-011 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 SHALL have port data_out  output  FIFO_WIDTH  read data.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write on a clk edge when wr_en=1 and (full=0 or read accepted same edge); stores data_in at wr_ptr, wr_ptr increments modulo FIFO_DEPTH.
REQ-017 SHALL accept a read on a clk edge when rd_en=1 and empty=0; rd_ptr increments modulo FIFO_DEPTH.
REQ-018 SHALL, FWFT=0, load data_out with the head word on the accepting edge (1-cycle latency) and hold data_out otherwise.
REQ-019 SHALL, FWFT=1, drive data_out with the head word whenever empty=0 (zero latency); rd_en acknowledges/pops it; data_out undefined-but-stable when empty.
REQ-020 SHALL update count: +1 write only, -1 read only, unchanged for both or neither; count never exceeds FIFO_DEPTH nor goes below 0.
REQ-021 SHALL derive flags from registered count: full=(count==FIFO_DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-022 SHALL, at full with wr_en=rd_en=1, accept both; read returns the pre-write head word; count stays FIFO_DEPTH.
REQ-023 SHALL, at empty with wr_en=rd_en=1, accept only the write (no bypass); count becomes 1; underflow sets.
REQ-024 SHALL set overflow when wr_en=1 and write is not accepted; set underflow when rd_en=1 and empty=1; both hold until clr_err=1 or reset; clr_err and a new error in the same cycle leave the flag set.
REQ-025 SHALL leave memory, pointers and count unchanged on rejected requests.

Reset
REQ-026 SHALL on reset=1 immediately clear wr_ptr, rd_ptr, count, overflow, underflow; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-027 SHALL clear data_out to 0 on reset (FWFT=0); memory contents are not reset.
REQ-028 SHALL discard any in-flight contents when reset asserts mid-operation; first read after release returns first word written after release.

Structure
REQ-029 SHALL place no types in a shared package; address width localparam computed locally via $clog2(FIFO_DEPTH).
REQ-030 SHALL be a single module with an inferred memory array; no sub-modules.

Verification
REQ-031 SHALL verify fill/drain: write 16 words 0x00..0x0F, read 16 -> data 0x00..0x0F in order, full after 16th write, empty after 16th read.
REQ-032 SHALL verify overflow: 17th write 0xAA at full -> rejected, overflow=1, count=16, later reads never return 0xAA; clr_err -> overflow=0.
REQ-033 SHALL verify simultaneous at full: wr 0x55 + rd -> read returns oldest word, count stays 16, 0x55 emerges last.
REQ-034 SHALL verify simultaneous at empty: wr 0x33 + rd -> count=1, underflow=1, next read returns 0x33.
REQ-035 SHALL verify thresholds and wrap: 40 mixed operations with pointer wrap -> almost_full asserts at count 14, almost_empty deasserts at count 3, scoreboard matches.
REQ-036 SHALL verify FWFT=1 and reset mid-operation: first write 0x7E visible on data_out the next cycle with no rd_en; reset at count 5 -> count=0, empty=1 immediately.
